// File: rtl/vga_vram_reader.sv
// CPU read-back port for the shared text-mode video SRAM.
// Steals the phase 6/7 bus slot of a character fetch when the write path leaves it free.
module vga_vram_reader #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 14
) (
    input  logic              CLK_25,
    input  logic              nRESET,
    input  logic [2:0]        X_PHASE,
    input  logic              WR_SLOT_BUSY,
    input  logic [ADDR_W-1:0] CPU_A,
    input  logic              CPU_nCS,
    input  logic              CPU_nRD,
    output logic              CPU_nWAIT,
    output logic [7:0]        CPU_DO,
    output logic              CPU_DOE,
    output logic              RD_REQ,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [7:0]        RAM_D
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_ACCESS,
        ST_HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [7:0]          cpu_do_q, cpu_do_d;
    logic                data_valid_q, data_valid_d;
    logic                rd_raw;
    logic                rd_sync;

    assign rd_raw  = ~CPU_nRD & ~CPU_nCS;
    assign rd_sync = sync_q[SYNC_STAGES-1];

    // WAIT/DOE are combinational so the CPU is stretched in the same cycle as its strobe.
    assign CPU_nWAIT = ~(rd_raw & ~data_valid_q);
    assign CPU_DOE   = rd_raw & data_valid_q;
    assign CPU_DO    = cpu_do_q;
    assign RD_REQ    = rd_req_q;
    assign RD_ADDR   = rd_addr_q;

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], rd_raw};
        state_d      = state_q;
        rd_req_d     = 1'b0;
        rd_addr_d    = rd_addr_q;
        cpu_do_d     = cpu_do_q;
        data_valid_d = data_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (rd_sync && !data_valid_q) begin
                    state_d   = ST_ARMED;
                    rd_addr_d = CPU_A;
                end
            end
            ST_ARMED: begin
                if (!rd_sync) begin
                    state_d = ST_IDLE;
                end else if (X_PHASE == 3'd5 && !WR_SLOT_BUSY) begin
                    state_d  = ST_ACCESS;
                    rd_req_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                // A slot, once claimed, always runs to phase 7; an abort only discards the byte.
                if (X_PHASE == 3'd6) begin
                    rd_req_d = 1'b1;
                end else if (X_PHASE == 3'd7) begin
                    cpu_do_d     = RAM_D;
                    data_valid_d = rd_sync;
                    state_d      = rd_sync ? ST_HOLD : ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!rd_sync) begin
                    data_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_25) begin
        if (!nRESET) begin
            state_q      <= ST_IDLE;
            sync_q       <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            cpu_do_q     <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            cpu_do_q     <= cpu_do_d;
            data_valid_q <= data_valid_d;
        end
    end

endmodule
